// File: rtl/kgp_alu_pkg.sv
// Shared ALU encodings and the multiply sequencer state encoding.
// Imported by the sequencer and by anything that drives or models the ALU.
package kgp_alu_pkg;

  localparam logic ALU_CLASS_ARITH = 1'b0;
  localparam logic ALU_CLASS_LOGIC = 1'b1;

  localparam logic ALU_FN_ADD = 1'b0;
  localparam logic ALU_FN_SUB = 1'b1;

  localparam logic [2:0] ALU_LOGIC_AND  = 3'b000;
  localparam logic [2:0] ALU_LOGIC_OR   = 3'b001;
  localparam logic [2:0] ALU_LOGIC_XOR  = 3'b010;
  localparam logic [2:0] ALU_LOGIC_NOR  = 3'b011;
  localparam logic [2:0] ALU_LOGIC_PASS = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the external ALU as its adder.
// One ALU add per multiplier bit; the 2*WIDTH product appears with a one-cycle done pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; ALU operands held at zero
// ST_RUN  | WIDTH add/shift iterations, ALU owned by the sequencer
// ST_DONE | product registered, done pulses for this single cycle
module alu_mul_sequencer
  import kgp_alu_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_fn,
  output logic             alu_fnclass,
  output logic [2:0]       alu_logicfn,
  input  logic [WIDTH-1:0] alu_value,
  input  logic             alu_carry
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] mcand_r;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] low_nxt;

  // The carry re-enters as the accumulator MSB, so the sum is never truncated.
  assign acc_nxt = {alu_carry, alu_value[WIDTH-1:1]};
  assign low_nxt = {alu_value[0], low[WIDTH-1:1]};

  assign busy        = (state != ST_IDLE);
  assign alu_x       = (state == ST_RUN) ? acc : '0;
  assign alu_y       = (state == ST_RUN && low[0]) ? mcand_r : '0;
  assign alu_fn      = ALU_FN_ADD;
  assign alu_fnclass = ALU_CLASS_ARITH;
  assign alu_logicfn = 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      low        <= '0;
      mcand_r    <= '0;
      count      <= '0;
      product_hi <= '0;
      product_lo <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            acc     <= '0;
            low     <= mplier;
            mcand_r <= mcand;
            count   <= '0;
          end
        end
        ST_RUN: begin
          acc   <= acc_nxt;
          low   <= low_nxt;
          count <= count + 1'b1;
          // Final iteration: capture the fully shifted result directly.
          if (count == LAST_ITER) begin
            state      <= ST_DONE;
            product_hi <= acc_nxt;
            product_lo <= low_nxt;
            done       <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer with a behavioural ALU closing the loop.
// Driver pushes hand-computed products; a negedge monitor pops and compares on done.
module tb_alu_mul_sequencer;
  import kgp_alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] mcand = '0;
  logic [W-1:0] mplier = '0;
  logic         busy, done;
  logic [W-1:0] product_hi, product_lo;
  logic [W-1:0] alu_x, alu_y, alu_value;
  logic         alu_fn, alu_fnclass, alu_carry;
  logic [2:0]   alu_logicfn;
  logic [W:0]   alu_res;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   fn_bad = 0;
  int   y_bad = 0;
  int   done_seen = 0;
  int   pushed = 0;
  bit   chk_y0 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo),
    .alu_x(alu_x), .alu_y(alu_y), .alu_fn(alu_fn), .alu_fnclass(alu_fnclass),
    .alu_logicfn(alu_logicfn), .alu_value(alu_value), .alu_carry(alu_carry)
  );

  // Behavioural stand-in for the datapath ALU.
  always_comb begin
    alu_res = '0;
    if (alu_fnclass == ALU_CLASS_ARITH) begin
      if (alu_fn == ALU_FN_ADD) alu_res = {1'b0, alu_x} + {1'b0, alu_y};
      else                      alu_res = {1'b0, alu_x} - {1'b0, alu_y};
    end else begin
      case (alu_logicfn)
        ALU_LOGIC_AND: alu_res = {1'b0, alu_x & alu_y};
        ALU_LOGIC_OR:  alu_res = {1'b0, alu_x | alu_y};
        ALU_LOGIC_XOR: alu_res = {1'b0, alu_x ^ alu_y};
        ALU_LOGIC_NOR: alu_res = {1'b0, ~(alu_x | alu_y)};
        default:       alu_res = {1'b0, alu_x};
      endcase
    end
  end
  assign alu_value = alu_res[W-1:0];
  assign alu_carry = alu_res[W];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && (alu_fn !== ALU_FN_ADD || alu_fnclass !== ALU_CLASS_ARITH || alu_logicfn !== 3'b000))
        fn_bad++;
      if (chk_y0 && busy && !done && alu_y !== '0)
        y_bad++;
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product_hi", 64'(product_hi), 64'(e.hi));
          check("product_lo", 64'(product_lo), 64'(e.lo));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Drive start for one IDLE cycle; expected done is 32 edges after the accepting edge.
  task automatic issue(input logic [W-1:0] mc, input logic [W-1:0] mp,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; mcand = mc; mplier = mp;
    @(posedge clk); #1;
    if (push) begin
      e.hi = hi; e.lo = lo; e.cyc = cyc + W;
      sb.push_back(e);
      pushed++;
    end
    @(negedge clk);
    start = 1'b0;
    mcand = 32'hA5A5_5A5A; mplier = 32'h5A5A_A5A5;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int acc_edge;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(product_hi), 64'd0);
    check("rst_lo", 64'(product_lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    wait_idle();
    issue(32'd65536, 32'd65536, 32'h1, 32'h0, 1'b1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    wait_idle();
    chk_y0 = 1'b1;
    issue(32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b1);
    wait_idle();
    chk_y0 = 1'b0;

    // Stray start mid-run must not disturb the op in flight.
    issue(32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; mcand = 32'd7; mplier = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-run aborts without a done pulse and clears the products.
    issue(32'd100, 32'd100, 32'd0, 32'd0, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(product_hi), 64'd0);
    check("abort_lo", 64'(product_lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd2, 32'd2, 32'd0, 32'd4, 1'b1);
    wait_idle();

    // Start held high: second op accepted on the first IDLE cycle after DONE.
    @(negedge clk);
    start = 1'b1; mcand = 32'h1234_5678; mplier = 32'h10;
    @(posedge clk); #1;
    acc_edge = cyc;
    e.hi = 32'h1; e.lo = 32'h2345_6780; e.cyc = acc_edge + W;
    sb.push_back(e); pushed++;
    mcand = 32'd1000; mplier = 32'd1000;
    e.hi = 32'h0; e.lo = 32'h000F_4240; e.cyc = acc_edge + W + 2 + W;
    sb.push_back(e); pushed++;
    while (cyc < acc_edge + W + 2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    check("fn_fnclass_while_busy", 64'(fn_bad), 64'd0);
    check("alu_y_zero_mcand", 64'(y_bad), 64'd0);
    check("done_pulses", 64'(done_seen), 64'(pushed));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
